// File: rtl/match_referee.sv
// rtl/match_referee.sv - sequential two-player match referee with optional early exit
module match_referee #(
    parameter int ROUNDS     = 9,
    parameter int CNT_W      = 4,
    parameter int EARLY_EXIT = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_round_valid,
    input  logic [1:0]       i_round_result,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_round,
    output logic [CNT_W-1:0] o_win,
    output logic [CNT_W-1:0] o_lose,
    output logic             o_fin,
    output logic             o_early,
    output logic [1:0]       o_printwinner
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] L_ROUNDS   = CNT_W'(ROUNDS);
    localparam logic [CNT_W:0]   L_ROUNDS_E = (CNT_W + 1)'(ROUNDS);

    localparam logic [1:0] PW_NONE = 2'b00;
    localparam logic [1:0] PW_TIE  = 2'b01;
    localparam logic [1:0] PW_P1   = 2'b10;
    localparam logic [1:0] PW_P2   = 2'b11;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_round;
    logic [CNT_W-1:0] r_win;
    logic [CNT_W-1:0] r_lose;
    logic             r_early;
    logic [1:0]       r_pw;
    logic [CNT_W-1:0] w_round_next;
    logic [CNT_W-1:0] w_win_next;
    logic [CNT_W-1:0] w_lose_next;
    logic             w_early_next;
    logic [1:0]       w_pw_next;

    // Candidate counters if the current round is accepted, and the decision on them
    logic             w_accept;
    logic [CNT_W-1:0] w_acc_round;
    logic [CNT_W-1:0] w_acc_win;
    logic [CNT_W-1:0] w_acc_lose;
    logic [CNT_W:0]   w_win_e;
    logic [CNT_W:0]   w_lose_e;
    logic [CNT_W:0]   w_rem_e;
    logic             w_last_round;
    logic             w_decided;
    logic [1:0]       w_acc_pw;

    assign w_accept     = i_round_valid & (i_round_result != 2'b00) & ~i_start;
    assign w_acc_round  = r_round + CNT_W'(1);
    assign w_acc_win    = (i_round_result == 2'b10) ? r_win + CNT_W'(1) : r_win;
    assign w_acc_lose   = (i_round_result == 2'b11) ? r_lose + CNT_W'(1) : r_lose;
    // Extra bit keeps "score + remaining" from overflowing the counter width
    assign w_win_e      = {1'b0, w_acc_win};
    assign w_lose_e     = {1'b0, w_acc_lose};
    assign w_rem_e      = L_ROUNDS_E - {1'b0, w_acc_round};
    assign w_last_round = (w_acc_round == L_ROUNDS);
    assign w_decided    = (w_win_e > w_lose_e + w_rem_e) | (w_lose_e > w_win_e + w_rem_e);
    assign w_acc_pw     = (w_acc_win > w_acc_lose) ? PW_P1 :
                          (w_acc_lose > w_acc_win) ? PW_P2 : PW_TIE;

    // State register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and next-counter logic; start always wins over a round in the same cycle
    always_comb begin
        w_state_next = r_state;
        w_round_next = r_round;
        w_win_next   = r_win;
        w_lose_next  = r_lose;
        w_early_next = r_early;
        w_pw_next    = r_pw;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_next = ST_PLAY;
                    w_round_next = '0;
                    w_win_next   = '0;
                    w_lose_next  = '0;
                    w_early_next = 1'b0;
                    w_pw_next    = PW_NONE;
                end
            end
            ST_PLAY: begin
                if (i_start) begin
                    w_round_next = '0;
                    w_win_next   = '0;
                    w_lose_next  = '0;
                end else if (w_accept) begin
                    w_round_next = w_acc_round;
                    w_win_next   = w_acc_win;
                    w_lose_next  = w_acc_lose;
                    if (w_last_round) begin
                        w_state_next = ST_DONE;
                        w_early_next = 1'b0;
                        w_pw_next    = w_acc_pw;
                    end else if ((EARLY_EXIT != 0) && w_decided) begin
                        w_state_next = ST_DONE;
                        w_early_next = 1'b1;
                        w_pw_next    = w_acc_pw;
                    end
                end
            end
            ST_DONE: begin
                if (i_start) begin
                    w_state_next = ST_PLAY;
                    w_round_next = '0;
                    w_win_next   = '0;
                    w_lose_next  = '0;
                    w_early_next = 1'b0;
                    w_pw_next    = PW_NONE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Counter, early flag and winner registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_round <= '0;
            r_win   <= '0;
            r_lose  <= '0;
            r_early <= 1'b0;
            r_pw    <= PW_NONE;
        end else begin
            r_round <= w_round_next;
            r_win   <= w_win_next;
            r_lose  <= w_lose_next;
            r_early <= w_early_next;
            r_pw    <= w_pw_next;
        end
    end

    assign o_busy        = (r_state == ST_PLAY);
    assign o_fin         = (r_state == ST_DONE);
    assign o_round       = r_round;
    assign o_win         = r_win;
    assign o_lose        = r_lose;
    assign o_early       = r_early;
    assign o_printwinner = r_pw;

endmodule

// File: tb/tb_match_referee.sv
// tb/tb_match_referee.sv - scoreboard bench for match_referee across three configurations
module tb_match_referee;

    typedef struct packed {
        logic       busy;
        logic       fin;
        logic       early;
        logic [7:0] rnd;
        logic [7:0] win;
        logic [7:0] lose;
        logic [1:0] pw;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       valid = 1'b0;
    logic [1:0] result = 2'b00;

    logic       d0_busy, d0_fin, d0_early;
    logic [3:0] d0_round, d0_win, d0_lose;
    logic [1:0] d0_pw;
    logic       d1_busy, d1_fin, d1_early;
    logic [3:0] d1_round, d1_win, d1_lose;
    logic [1:0] d1_pw;
    logic       d2_busy, d2_fin, d2_early;
    logic [1:0] d2_round, d2_win, d2_lose;
    logic [1:0] d2_pw;

    int checks = 0;
    int errors = 0;

    int P_R[3]  = '{9, 9, 3};
    int P_EE[3] = '{1, 0, 1};
    int m_st[3];
    int m_rnd[3];
    int m_win[3];
    int m_lose[3];
    int m_early[3];
    int m_pw[3];
    exp_t q[3][$];

    always #5 clk = ~clk;

    match_referee #(.ROUNDS(9), .CNT_W(4), .EARLY_EXIT(1)) u_d0 (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_round_valid(valid),
        .i_round_result(result), .o_busy(d0_busy), .o_round(d0_round), .o_win(d0_win),
        .o_lose(d0_lose), .o_fin(d0_fin), .o_early(d0_early), .o_printwinner(d0_pw)
    );

    match_referee #(.ROUNDS(9), .CNT_W(4), .EARLY_EXIT(0)) u_d1 (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_round_valid(valid),
        .i_round_result(result), .o_busy(d1_busy), .o_round(d1_round), .o_win(d1_win),
        .o_lose(d1_lose), .o_fin(d1_fin), .o_early(d1_early), .o_printwinner(d1_pw)
    );

    match_referee #(.ROUNDS(3), .CNT_W(2), .EARLY_EXIT(1)) u_d2 (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_round_valid(valid),
        .i_round_result(result), .o_busy(d2_busy), .o_round(d2_round), .o_win(d2_win),
        .o_lose(d2_lose), .o_fin(d2_fin), .o_early(d2_early), .o_printwinner(d2_pw)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t actual(input int i);
        exp_t a;
        a = '0;
        case (i)
            0: begin
                a.busy = d0_busy; a.fin = d0_fin; a.early = d0_early;
                a.rnd = 8'(d0_round); a.win = 8'(d0_win); a.lose = 8'(d0_lose); a.pw = d0_pw;
            end
            1: begin
                a.busy = d1_busy; a.fin = d1_fin; a.early = d1_early;
                a.rnd = 8'(d1_round); a.win = 8'(d1_win); a.lose = 8'(d1_lose); a.pw = d1_pw;
            end
            default: begin
                a.busy = d2_busy; a.fin = d2_fin; a.early = d2_early;
                a.rnd = 8'(d2_round); a.win = 8'(d2_win); a.lose = 8'(d2_lose); a.pw = d2_pw;
            end
        endcase
        return a;
    endfunction

    function automatic exp_t model_exp(input int i);
        exp_t e;
        e.busy  = (m_st[i] == 1);
        e.fin   = (m_st[i] == 2);
        e.early = m_early[i][0];
        e.rnd   = 8'(m_rnd[i]);
        e.win   = 8'(m_win[i]);
        e.lose  = 8'(m_lose[i]);
        e.pw    = 2'(m_pw[i]);
        return e;
    endfunction

    task automatic model_reset(input int i);
        m_st[i] = 0; m_rnd[i] = 0; m_win[i] = 0; m_lose[i] = 0; m_early[i] = 0; m_pw[i] = 0;
    endtask

    task automatic model_clear(input int i);
        m_st[i] = 1; m_rnd[i] = 0; m_win[i] = 0; m_lose[i] = 0; m_early[i] = 0; m_pw[i] = 0;
    endtask

    task automatic model_step(input int i, input logic s, input logic v, input logic [1:0] r);
        int lead;
        if (m_st[i] == 0 || m_st[i] == 2) begin
            if (s) model_clear(i);
        end else if (s) begin
            model_clear(i);
        end else if (v && r != 2'b00) begin
            m_rnd[i]++;
            if (r == 2'b10) m_win[i]++;
            if (r == 2'b11) m_lose[i]++;
            lead = m_win[i] - m_lose[i];
            if (lead < 0) lead = -lead;
            if (m_rnd[i] == P_R[i] || (P_EE[i] != 0 && lead > P_R[i] - m_rnd[i])) begin
                m_early[i] = (m_rnd[i] == P_R[i]) ? 0 : 1;
                m_st[i] = 2;
                m_pw[i] = (m_win[i] > m_lose[i]) ? 2 : (m_lose[i] > m_win[i]) ? 3 : 1;
            end
        end
    endtask

    task automatic compare_inst(input int i);
        exp_t e;
        exp_t a;
        if (q[i].size() == 0) begin
            chk($sformatf("d%0d_sb_empty", i), 0, 1);
        end else begin
            e = q[i].pop_front();
            a = actual(i);
            chk($sformatf("d%0d_busy", i), int'(a.busy), int'(e.busy));
            chk($sformatf("d%0d_fin", i), int'(a.fin), int'(e.fin));
            chk($sformatf("d%0d_early", i), int'(a.early), int'(e.early));
            chk($sformatf("d%0d_round", i), int'(a.rnd), int'(e.rnd));
            chk($sformatf("d%0d_win", i), int'(a.win), int'(e.win));
            chk($sformatf("d%0d_lose", i), int'(a.lose), int'(e.lose));
            chk($sformatf("d%0d_pw", i), int'(a.pw), int'(e.pw));
        end
    endtask

    task automatic cycle(input logic s, input logic v, input logic [1:0] r);
        @(negedge clk);
        start = s; valid = v; result = r;
        for (int i = 0; i < 3; i++) begin
            model_step(i, s, v, r);
            q[i].push_back(model_exp(i));
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) compare_inst(i);
    endtask

    task automatic async_reset();
        @(negedge clk);
        start = 1'b0; valid = 1'b0; result = 2'b00;
        #2 reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            model_reset(i);
            q[i].push_back(model_exp(i));
            compare_inst(i);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [1:0] seq1 [9];
        seq1 = '{2'b10, 2'b11, 2'b10, 2'b11, 2'b01, 2'b10, 2'b11, 2'b10, 2'b11};

        for (int i = 0; i < 3; i++) model_reset(i);
        #3;
        for (int i = 0; i < 3; i++) begin
            q[i].push_back(model_exp(i));
            compare_inst(i);
        end
        @(negedge clk);
        reset = 1'b0;

        // Rounds before any start are ignored
        cycle(1'b0, 1'b1, 2'b10);
        chk("idle_ignore_round", int'(d0_round), 0);

        // Full nine-round drawn match
        cycle(1'b1, 1'b0, 2'b00);
        chk("start_busy", int'(d0_busy), 1);
        for (int k = 0; k < 9; k++) cycle(1'b0, 1'b1, seq1[k]);
        chk("tp1_fin", int'(d0_fin), 1);
        chk("tp1_round", int'(d0_round), 9);
        chk("tp1_win", int'(d0_win), 4);
        chk("tp1_lose", int'(d0_lose), 4);
        chk("tp1_pw", int'(d0_pw), 1);
        chk("tp1_early", int'(d0_early), 0);

        // Five straight p1 wins: early exit on d0, d1 plays on
        cycle(1'b1, 1'b0, 2'b00);
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, 2'b10);
        chk("tp2_not_yet", int'(d0_fin), 0);
        cycle(1'b0, 1'b1, 2'b10);
        chk("tp2_fin", int'(d0_fin), 1);
        chk("tp2_round", int'(d0_round), 5);
        chk("tp2_pw", int'(d0_pw), 2);
        chk("tp2_early", int'(d0_early), 1);
        chk("tp3_busy", int'(d1_busy), 1);
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, 2'b11);
        chk("tp2_frozen", int'(d0_round), 5);
        chk("tp3_fin", int'(d1_fin), 1);
        chk("tp3_round", int'(d1_round), 9);
        chk("tp3_win", int'(d1_win), 5);
        chk("tp3_lose", int'(d1_lose), 4);
        chk("tp3_pw", int'(d1_pw), 2);
        chk("tp3_early", int'(d1_early), 0);

        // No-op round and start overriding a valid round
        cycle(1'b1, 1'b0, 2'b00);
        cycle(1'b0, 1'b1, 2'b10);
        cycle(1'b0, 1'b1, 2'b00);
        chk("noop_round", int'(d0_round), 1);
        cycle(1'b1, 1'b1, 2'b11);
        chk("restart_round", int'(d0_round), 0);
        chk("restart_lose", int'(d0_lose), 0);
        chk("restart_busy", int'(d0_busy), 1);

        // Asynchronous reset mid-match, then rounds before start ignored
        cycle(1'b0, 1'b1, 2'b10);
        cycle(1'b0, 1'b1, 2'b11);
        cycle(1'b0, 1'b1, 2'b01);
        chk("pre_reset_round", int'(d0_round), 3);
        async_reset();
        chk("reset_round", int'(d0_round), 0);
        chk("reset_busy", int'(d0_busy), 0);
        cycle(1'b0, 1'b1, 2'b10);
        chk("post_reset_idle", int'(d0_round), 0);

        // Three-round config: p2 decides after two rounds
        cycle(1'b1, 1'b0, 2'b00);
        cycle(1'b0, 1'b1, 2'b11);
        cycle(1'b0, 1'b1, 2'b11);
        chk("r3_fin", int'(d2_fin), 1);
        chk("r3_pw", int'(d2_pw), 3);
        chk("r3_early", int'(d2_early), 1);
        cycle(1'b1, 1'b0, 2'b00);
        chk("r3_restart_fin", int'(d2_fin), 0);
        chk("r3_restart_busy", int'(d2_busy), 1);
        chk("r3_restart_lose", int'(d2_lose), 0);

        // Random back-to-back traffic checked against the model
        for (int k = 0; k < 60; k++) begin
            cycle($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)));
        end

        // Reset while a DONE state is likely held
        async_reset();
        cycle(1'b0, 1'b0, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
